// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller placed beside the ID stage. It decides, in the
//   same cycle, whether the PC, IF/ID and ID/EX registers load, hold or take a
//   bubble. It handles three cases:
//     - taken-branch flushes
//     - load-use stalls
//     - multi-cycle MDU (mul/div) occupancy of EX
//   It also keeps a saturating count of stalled cycles.
//
// Parameters:
//   MDU_CYCLES    cycles an MDU op holds the pipeline (2..15)
//   CNT_W         width of the MDU countdown, 2**CNT_W > MDU_CYCLES
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   if_id_rs/rt   source fields of the instruction in IF/ID
//   if_id_uses_rt IF/ID instruction reads rt
//   id_ex_memread ID/EX instruction is a load
//   id_ex_dst     destination register of the ID/EX instruction
//   mdu_start     ID/EX instruction is an MDU op
//   branch_taken  EX resolved a taken branch/jump this cycle
//   pc_wr, if_id_wr, id_ex_wr          register write enables
//   if_id_flush, id_ex_flush           NOP/bubble insertion
//   ex_mem_bubble EX/MEM captures a bubble this edge
//   stall_cycles  saturating count of cycles with pc_wr=0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        if_id_uses_rt,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_dst,
    input  logic        mdu_start,
    input  logic        branch_taken,
    output logic        pc_wr,
    output logic        if_id_wr,
    output logic        if_id_flush,
    output logic        id_ex_wr,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               served_q, served_d;
    logic [15:0]        stall_q, stall_d;

    logic               lu;
    logic               mdu_req;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = id_ex_memread && (id_ex_dst != 5'd0) &&
                ((id_ex_dst == if_id_rs) || (if_id_uses_rt && (id_ex_dst == if_id_rt)));

    // The MDU op that just finished its hold is still in ID/EX for one cycle;
    // served_q keeps it from starting a second hold.
    assign mdu_req = mdu_start && !served_q;

    always_comb begin
        pc_wr         = 1'b0;
        if_id_wr      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_wr      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        served_d      = served_q;
        stall_d       = stall_q;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    pc_wr    = 1'b1;
                    if_id_wr = 1'b1;
                    id_ex_wr = 1'b1;
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mdu_req) begin
                        pc_wr         = 1'b0;
                        if_id_wr      = 1'b0;
                        id_ex_wr      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_d       = MDU_WAIT;
                        // The detect cycle counts as the first hold cycle.
                        cnt_d         = CNT_W'(MDU_CYCLES - 1);
                    end else if (lu) begin
                        pc_wr       = 1'b0;
                        if_id_wr    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                    // A real new instruction entering ID/EX re-arms MDU detection.
                    if (id_ex_wr && !id_ex_flush) begin
                        served_d = 1'b0;
                    end
                end
                MDU_WAIT: begin
                    ex_mem_bubble = 1'b1;
                    cnt_d         = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = RUN;
                        served_d = 1'b1;
                    end
                end
            endcase

            if (!pc_wr && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            served_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule
